// File: rtl/mips_mc_ctrl_if.sv
// Control/datapath bundle for the multi-cycle MIPS controller.
// master: controller side (consumes IR fields and the ALU zero flag, drives enables/selects).
// slave : datapath side.
interface mips_mc_ctrl_if #(
    parameter int OP_W = 6,
    parameter int FN_W = 6
);
    logic [OP_W-1:0] op;
    logic [FN_W-1:0] funct;
    logic            zero;
    logic            PCWr;
    logic            IRWr;
    logic            RFWr;
    logic            DMWr;
    logic [1:0]      NPCOp;
    logic [1:0]      WRSel;
    logic [1:0]      WDSel;
    logic [1:0]      EXTOp;
    logic            BSel;
    logic [2:0]      ALUOp;

    modport master (
        input  op, funct, zero,
        output PCWr, IRWr, RFWr, DMWr, NPCOp, WRSel, WDSel, EXTOp, BSel, ALUOp
    );

    modport slave (
        output op, funct, zero,
        input  PCWr, IRWr, RFWr, DMWr, NPCOp, WRSel, WDSel, EXTOp, BSel, ALUOp
    );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM: fetch, decode, execute, memory, writeback.
// Outputs are combinational from state plus op/funct/zero; rst forces them low.
// Optional feature macro: MC_CTRL_BNE_EN (adds bne handling through the BR state).
//
// state | meaning
// FETCH | load IR, PC <= PC+4
// DCD   | decode opcode/funct, no writes
// MA    | memory address = rs + sign-extended imm
// MR    | data memory read cycle
// MW    | data memory write (sw)
// WBM   | write DM read data into rt (lw)
// EXE   | ALU operation for R-type / ori / lui
// WBA   | write ALU result to rd (R-type) or rt (imm)
// BR    | compare, conditionally take branch target
// JMP   | j / jal / jr
module mips_mc_ctrl #(
    parameter int OP_W = 6,
    parameter int FN_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    mips_mc_ctrl_if.master   bus
);

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
`ifdef MC_CTRL_BNE_EN
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
`endif
    localparam logic [FN_W-1:0] FN_ADDU  = 6'b100001;
    localparam logic [FN_W-1:0] FN_SUBU  = 6'b100011;
    localparam logic [FN_W-1:0] FN_SLT   = 6'b101010;
    localparam logic [FN_W-1:0] FN_JR    = 6'b001000;

    typedef enum logic [3:0] {
        FETCH = 4'd0,
        DCD   = 4'd1,
        MA    = 4'd2,
        MR    = 4'd3,
        MW    = 4'd4,
        WBM   = 4'd5,
        EXE   = 4'd6,
        WBA   = 4'd7,
        BR    = 4'd8,
        JMP   = 4'd9
    } state_t;

    state_t state, nx;

    logic is_rtype, is_alu_r, is_jr;
    logic is_lw, is_sw, is_ori, is_lui, is_beq, is_j, is_jal;

    assign is_rtype = (bus.op == OP_RTYPE);
    assign is_alu_r = is_rtype && ((bus.funct == FN_ADDU) || (bus.funct == FN_SUBU) ||
                                   (bus.funct == FN_SLT));
    assign is_jr    = is_rtype && (bus.funct == FN_JR);
    assign is_lw    = (bus.op == OP_LW);
    assign is_sw    = (bus.op == OP_SW);
    assign is_ori   = (bus.op == OP_ORI);
    assign is_lui   = (bus.op == OP_LUI);
    assign is_beq   = (bus.op == OP_BEQ);
    assign is_j     = (bus.op == OP_J);
    assign is_jal   = (bus.op == OP_JAL);
`ifdef MC_CTRL_BNE_EN
    logic is_bne;
    assign is_bne   = (bus.op == OP_BNE);
`endif

    logic       pc_wr, ir_wr, rf_wr, dm_wr, b_sel;
    logic [1:0] npc_op, wr_sel, wd_sel, ext_op;
    logic [2:0] alu_op;

    // ALU configuration shared by EXE and WBA so the result stays stable during writeback.
    logic       exe_bsel;
    logic [1:0] exe_ext;
    logic [2:0] exe_alu;

    // Decode ALU operand/operation for arithmetic-class instructions.
    always_comb begin
        exe_bsel = 1'b0;
        exe_ext  = 2'b00;
        exe_alu  = 3'b000;
        if (is_ori) begin
            exe_bsel = 1'b1;
            exe_ext  = 2'b00;
            exe_alu  = 3'b010;
        end else if (is_lui) begin
            exe_bsel = 1'b1;
            exe_ext  = 2'b10;
            exe_alu  = 3'b010;
        end else if (is_rtype) begin
            case (bus.funct)
                FN_SUBU: exe_alu = 3'b001;
                FN_SLT:  exe_alu = 3'b011;
                default: exe_alu = 3'b000;
            endcase
        end
    end

    // State register; reset returns to FETCH immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= nx;
    end

    // Next-state and raw control outputs from the current state.
    always_comb begin
        nx     = FETCH;
        pc_wr  = 1'b0;
        ir_wr  = 1'b0;
        rf_wr  = 1'b0;
        dm_wr  = 1'b0;
        npc_op = 2'b00;
        wr_sel = 2'b00;
        wd_sel = 2'b00;
        ext_op = 2'b00;
        b_sel  = 1'b0;
        alu_op = 3'b000;
        case (state)
            FETCH: begin
                ir_wr = 1'b1;
                pc_wr = 1'b1;
                nx    = DCD;
            end
            DCD: begin
                if (is_lw || is_sw)                 nx = MA;
                else if (is_alu_r || is_ori || is_lui) nx = EXE;
                else if (is_beq)                    nx = BR;
`ifdef MC_CTRL_BNE_EN
                else if (is_bne)                    nx = BR;
`endif
                else if (is_j || is_jal || is_jr)   nx = JMP;
                else                                nx = FETCH;
            end
            MA: begin
                b_sel  = 1'b1;
                ext_op = 2'b01;
                alu_op = 3'b000;
                nx     = is_sw ? MW : MR;
            end
            MR: nx = WBM;
            MW: begin
                dm_wr = 1'b1;
                nx    = FETCH;
            end
            WBM: begin
                rf_wr  = 1'b1;
                wr_sel = 2'b00;
                wd_sel = 2'b01;
                nx     = FETCH;
            end
            EXE: begin
                b_sel  = exe_bsel;
                ext_op = exe_ext;
                alu_op = exe_alu;
                nx     = WBA;
            end
            WBA: begin
                rf_wr  = 1'b1;
                wd_sel = 2'b00;
                wr_sel = is_rtype ? 2'b01 : 2'b00;
                b_sel  = exe_bsel;
                ext_op = exe_ext;
                alu_op = exe_alu;
                nx     = FETCH;
            end
            BR: begin
                alu_op = 3'b001;
                b_sel  = 1'b0;
                npc_op = 2'b01;
                pc_wr  = bus.zero;
`ifdef MC_CTRL_BNE_EN
                if (is_bne) pc_wr = ~bus.zero;
`endif
                nx     = FETCH;
            end
            JMP: begin
                pc_wr  = 1'b1;
                npc_op = is_jr ? 2'b11 : 2'b10;
                if (is_jal) begin
                    rf_wr  = 1'b1;
                    wr_sel = 2'b10;
                    wd_sel = 2'b10;
                end
                nx     = FETCH;
            end
            default: nx = FETCH;
        endcase
    end

    // Reset suppresses every write and zeroes every select, even mid-cycle.
    always_comb begin
        bus.PCWr  = pc_wr  & ~rst;
        bus.IRWr  = ir_wr  & ~rst;
        bus.RFWr  = rf_wr  & ~rst;
        bus.DMWr  = dm_wr  & ~rst;
        bus.NPCOp = rst ? 2'b00  : npc_op;
        bus.WRSel = rst ? 2'b00  : wr_sel;
        bus.WDSel = rst ? 2'b00  : wd_sel;
        bus.EXTOp = rst ? 2'b00  : ext_op;
        bus.BSel  = b_sel  & ~rst;
        bus.ALUOp = rst ? 3'b000 : alu_op;
    end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
Multi-cycle MIPS control FSM. It sequences fetch, decode, execute, memory and writeback, and drives the write enables and datapath selects. It generates PCWr and NPCOp, which the PC register and next-PC logic consume. One instruction completes in 3–5 cycles.

Parameters:
OP_W, 6, opcode field width
FN_W, 6, funct field width

Ports:
clk  in  1  clock, rising-edge
rst  in  1  reset, asynchronous, active-high
op  in  6  instruction[31:26], taken from the IR
funct  in  6  instruction[5:0], taken from the IR
zero  in  1  ALU zero flag from the current cycle's compare
PCWr  out  1  PC write enable
IRWr  out  1  instruction register write enable
RFWr  out  1  register file write enable
DMWr  out  1  data memory write enable
NPCOp  out  2  next-PC select: 00 PC+4, 01 branch target, 10 jump target, 11 rs (jr)
WRSel  out  2  write-register select: 00 rt, 01 rd, 10 $31
WDSel  out  2  write-data select: 00 ALU result, 01 DM read data, 10 PC (already PC+4)
EXTOp  out  2  immediate extension: 00 zero-extend, 01 sign-extend, 10 shift left by 16 (lui)
BSel  out  1  ALU B operand: 0 rt, 1 extended immediate
ALUOp  out  3  ALU operation: 000 add, 001 sub, 010 or, 011 slt

Behaviour:
- Reset:
  - rst high puts the state into FETCH immediately (asynchronous).
  - While rst is high, all write enables (PCWr, IRWr, RFWr, DMWr) are forced to 0 and all selects are 0.
- Outputs are combinational from the current state, plus op/funct/zero. No output registers.
- State encoding, 4 bits: FETCH=0, DCD=1, MA=2, MR=3, MW=4, WBM=5, EXE=6, WBA=7, BR=8, JMP=9. Codes 10–15 are illegal and go to FETCH on the next edge with no writes.
- FETCH:
  - Asserts IRWr=1, PCWr=1, NPCOp=00.
  - Next state is always DCD.
- DCD: no writes. Next state by opcode:
  - lw (100011) or sw (101011) → MA
  - R-type (000000) with funct addu (100001), subu (100011) or slt (101010) → EXE
  - ori (001101) or lui (001111) → EXE
  - beq (000100) → BR
  - j (000010), jal (000011), or R-type with funct jr (001000) → JMP
  - Any other op/funct → FETCH. This is a NOP; the PC has already advanced.
- MA:
  - BSel=1, EXTOp=01, ALUOp=000.
  - Next state is MR for lw, MW for sw.
- MR: read cycle, no writes. Next state WBM.
- MW: DMWr=1. Next state FETCH.
- WBM: RFWr=1, WRSel=00, WDSel=01. Next state FETCH.
- EXE: ALU settings by instruction. Next state WBA.
  - R-type: BSel=0; ALUOp is 000 for addu, 001 for subu, 011 for slt.
  - ori: BSel=1, EXTOp=00, ALUOp=010.
  - lui: BSel=1, EXTOp=10, ALUOp=010. The ALU or's the value with $0 via the rs=0 encoding; the datapath guarantees rs=0.
- WBA:
  - RFWr=1, WDSel=00. WRSel=01 for R-type, 00 for ori/lui.
  - Holds the same ALUOp/BSel/EXTOp as EXE.
  - Next state FETCH.
- BR:
  - ALUOp=001, BSel=0, NPCOp=01, PCWr=zero.
  - Next state FETCH.
- JMP:
  - PCWr=1.
  - NPCOp=10 for j/jal, 11 for jr.
  - jal also asserts RFWr=1, WRSel=10, WDSel=10, writing PC+4 into $31.
  - Next state FETCH.
- Latency in cycles, from FETCH to the next FETCH: lw 5; sw, R-type, ori, lui 4; beq, j, jal, jr 3; unknown opcode 2.
- There is no branch delay slot.
- At most one of PCWr/IRWr is paired with DMWr in any state; DMWr and RFWr are never both 1.
- Reset asserted mid-instruction:
  - Any partial write in that cycle is suppressed.
  - After rst falls, the first rising edge is processed in FETCH.

Optional Feature:
- Macro: MC_CTRL_BNE_EN
- When defined:
  - bne (000101) in DCD goes to BR.
  - In BR for bne: PCWr=~zero, NPCOp=01, ALUOp=001.
- When undefined: bne is an unknown opcode. DCD goes to FETCH with no writes.

Test Plan:
- Reset and first fetch: assert rst mid-cycle → state FETCH and all enables 0 while high. Release rst, first edge → FETCH with IRWr=1, PCWr=1, NPCOp=00.
- addu (op=000000, funct=100001): states go FETCH→DCD→EXE→WBA→FETCH. In WBA: RFWr=1, WRSel=01, WDSel=00, ALUOp=000. 4 cycles total.
- lw then sw:
  - lw: MA shows BSel=1, EXTOp=01; WBM shows RFWr=1, WDSel=01; 5 cycles.
  - sw: MW shows DMWr=1 with RFWr=0; 4 cycles.
- beq with zero=1 then zero=0: BR shows NPCOp=01. PCWr=1 in the first case, PCWr=0 in the second. Both return to FETCH.
- jal and jr:
  - jal: JMP shows PCWr=1, NPCOp=10, RFWr=1, WRSel=10, WDSel=10.
  - jr (funct=001000): NPCOp=11, RFWr=0.
- Unknown opcode 000101:
  - Without MC_CTRL_BNE_EN: DCD goes to FETCH with no writes.
  - With the macro and zero=0: BR shows PCWr=1.
